bnn_weight_streamer: RTL and testbench

//  Transmit side of the BNN nibble weight-load protocol. Holds a local image of all

---
 rtl/bnn_pkg.sv | 16 +
 rtl/bnn_weight_regfile.sv | 35 +++
 rtl/bnn_weight_streamer.sv | 129 ++++++++++++
 tb/tb_bnn_weight_streamer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared constants and stream FSM state type for the BNN nibble weight streamer.
package bnn_pkg;

  localparam int NUM_NEURONS = 12;          // layer1 + layer2 neurons
  localparam int WEIGHT_W    = 8;           // bits per neuron weight vector
  localparam int NIBBLE_W    = WEIGHT_W/2;  // bits per transfer beat
  localparam int IDX_W       = 5;           // neuron index / write address width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_FIN  = 2'd3
  } stream_state_t;

endpackage

// File: rtl/bnn_weight_regfile.sv
// Local image of all neuron weights: synchronous write, asynchronous read by index.
// Out-of-range addresses never match an entry, so such writes are dropped and
// such reads return 0.
module bnn_weight_regfile
  import bnn_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_addr,
  input  logic [WEIGHT_W-1:0] wr_data,
  input  logic [IDX_W-1:0]    rd_addr,
  output logic [WEIGHT_W-1:0] rd_data
);

  logic [WEIGHT_W-1:0] mem [NUM_NEURONS];

  // Image storage; cleared on reset, one entry written per strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_NEURONS; i++)
        if (wr_addr == IDX_W'(i)) mem[i] <= wr_data;
    end
  end

  // Read mux by index; compare-based so no oversized array index is needed.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_NEURONS; i++)
      if (rd_addr == IDX_W'(i)) rd_data = mem[i];
  end

endmodule

// File: rtl/bnn_weight_streamer.sv
// Transmit side of the BNN nibble weight-load protocol. Streams the local weight
// image as low nibble then high nibble per neuron, neuron 0 first, with load_en_o
// high for the whole stream. Abort is only honoured after a HI beat so the
// receiver never loses nibble phase.
// Optional build macro: BNN_STREAM_CHECKSUM_EN adds a running XOR of the streamed
// weights on the checksum port; without it checksum is tied to 0.
module bnn_weight_streamer
  import bnn_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_addr,
  input  logic [WEIGHT_W-1:0] wr_data,
  input  logic                start,
  input  logic                abort,
  output logic                load_en_o,
  output logic [NIBBLE_W-1:0] nibble_o,
  output logic [IDX_W-1:0]    neuron_idx_o,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [WEIGHT_W-1:0] checksum
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS-1);

  stream_state_t       state;
  logic                abort_pend;
  logic                wr_ok;
  logic [IDX_W-1:0]    rd_addr;
  logic [WEIGHT_W-1:0] rd_data;

  // Image is frozen outside IDLE and on the cycle a start is taken.
  assign wr_ok = wr_en && ena && (state == ST_IDLE) && !start &&
                 (wr_addr < IDX_W'(NUM_NEURONS));

  // Read the weight needed for the next beat: neuron 0 at start, the current
  // neuron for its HI nibble, the following neuron for its LO nibble.
  always_comb begin
    rd_addr = neuron_idx_o;
    case (state)
      ST_IDLE: rd_addr = '0;
      ST_HI:   rd_addr = neuron_idx_o + IDX_W'(1);
      default: rd_addr = neuron_idx_o;
    endcase
  end

  bnn_weight_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Stream FSM with registered outputs; everything freezes while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      abort_pend   <= 1'b0;
      load_en_o    <= 1'b0;
      nibble_o     <= '0;
      neuron_idx_o <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else if (ena) begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_LO;
            load_en_o    <= 1'b1;
            busy         <= 1'b1;
            neuron_idx_o <= '0;
            nibble_o     <= rd_data[NIBBLE_W-1:0];
            abort_pend   <= 1'b0;
          end
        end
        ST_LO: begin
          state      <= ST_HI;
          nibble_o   <= rd_data[WEIGHT_W-1:NIBBLE_W];
          abort_pend <= abort_pend | abort;
        end
        ST_HI: begin
          if (abort_pend || abort) begin
            state      <= ST_IDLE;
            load_en_o  <= 1'b0;
            busy       <= 1'b0;
            nibble_o   <= '0;
            aborted    <= 1'b1;
            abort_pend <= 1'b0;
          end else if (neuron_idx_o == LAST_IDX) begin
            state     <= ST_FIN;
            load_en_o <= 1'b0;
            busy      <= 1'b0;
            nibble_o  <= '0;
            done      <= 1'b1;
          end else begin
            state        <= ST_LO;
            neuron_idx_o <= neuron_idx_o + IDX_W'(1);
            nibble_o     <= rd_data[NIBBLE_W-1:0];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BNN_STREAM_CHECKSUM_EN
  // Running XOR: cleared when a stream starts, folds in each neuron as its HI beat is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (ena) begin
      if (state == ST_IDLE && start) checksum <= '0;
      else if (state == ST_LO)       checksum <= checksum ^ rd_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Directed bench for bnn_weight_streamer: reset, full streams, ena stall,
// abort, frozen-image writes, mid-stream reset and the checksum.
module tb_bnn_weight_streamer;
  import bnn_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n, ena, wr_en, start, abort;
  logic [IDX_W-1:0]    wr_addr;
  logic [WEIGHT_W-1:0] wr_data;
  logic                load_en_o, busy, done, aborted;
  logic [NIBBLE_W-1:0] nibble_o;
  logic [IDX_W-1:0]    neuron_idx_o;
  logic [WEIGHT_W-1:0] checksum;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] img [NUM_NEURONS];

  bnn_weight_streamer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .abort(abort), .load_en_o(load_en_o),
    .nibble_o(nibble_o), .neuron_idx_o(neuron_idx_o), .busy(busy), .done(done),
    .aborted(aborted), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = IDX_W'(a); wr_data = d;
    step;
    wr_en = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_le"},   load_en_o,    0);
    chk({tag, "_busy"}, busy,         0);
    chk({tag, "_nib"},  nibble_o,     0);
    chk({tag, "_idx"},  neuron_idx_o, 0);
    chk({tag, "_done"}, done,         0);
    chk({tag, "_abt"},  aborted,      0);
    chk({tag, "_cs"},   checksum,     0);
  endtask

  // Run one stream against the img model. stall_k: beat at which ena drops for
  // 3 cycles; abort_n: neuron whose LO beat carries abort; wrbusy_k: beat with
  // a write to addr 2 (must be ignored). -1 disables each.
  task automatic stream(input int stall_k, input int abort_n, input int wrbusy_k);
    int         i;
    logic [3:0] en;
    logic [7:0] cs;
    cs = 8'h00;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int k = 1; k <= 2*NUM_NEURONS; k++) begin
      i  = (k-1)/2;
      en = (k % 2 == 1) ? img[i][3:0] : img[i][7:4];
      chk($sformatf("nib%0d", k),  nibble_o,     en);
      chk($sformatf("le%0d", k),   load_en_o,    1);
      chk($sformatf("busy%0d", k), busy,         1);
      chk($sformatf("idx%0d", k),  neuron_idx_o, i);
      chk($sformatf("done%0d", k), done,         0);
      if (k % 2 == 0) cs = cs ^ img[i];
      if (k == stall_k) begin
        ena = 1'b0;
        repeat (3) begin
          step;
          chk("hold_nib", nibble_o,     en);
          chk("hold_le",  load_en_o,    1);
          chk("hold_idx", neuron_idx_o, i);
        end
        ena = 1'b1;
      end
      if (k == 2*abort_n+1) abort = 1'b1;
      if (k == wrbusy_k) begin
        wr_en = 1'b1; wr_addr = IDX_W'(2); wr_data = 8'hFF;
      end
      step;
      abort = 1'b0;
      wr_en = 1'b0;
      if (k == 2*abort_n+2) begin
        chk("abt_pulse", aborted,   1);
        chk("abt_busy",  busy,      0);
        chk("abt_le",    load_en_o, 0);
        chk("abt_done",  done,      0);
        step;
        chk("abt_clr",   aborted,   0);
        chk("abt_nodone", done,     0);
        return;
      end
    end
    chk("done",    done,      1);
    chk("fin_busy", busy,     0);
    chk("fin_le",  load_en_o, 0);
    chk("fin_abt", aborted,   0);
`ifdef BNN_STREAM_CHECKSUM_EN
    chk("checksum", checksum, cs);
`else
    chk("checksum", checksum, 0);
`endif
    step;
    chk("done_clr", done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; start = 1'b0; abort = 1'b0;
    wr_addr = '0; wr_data = '0;
    for (int n = 0; n < NUM_NEURONS; n++) img[n] = 8'h00;
    repeat (2) step;
    chk_quiet("rst");
    rst_n = 1'b1;
    step;

    // basic stream: w0=A5, w11=3C, rest 0; done 25 cycles after start edge
    wr(0, 8'hA5);  img[0]  = 8'hA5;
    wr(11, 8'h3C); img[11] = 8'h3C;
    stream(-1, -1, -1);

    // ena low for 3 cycles at beat 7: done slips to start+28
    stream(7, -1, -1);

    // abort during LO of neuron 4
    stream(-1, 4, -1);
    chk("post_abt_busy", busy, 0);

    // write while busy and out-of-range write are both dropped
    stream(-1, -1, 5);
    wr(12, 8'h77);
    stream(-1, -1, -1);

    // reset mid-stream
    start = 1'b1; step; start = 1'b0;
    repeat (4) step;
    chk("mid_le", load_en_o, 1);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk_quiet("midrst");
    for (int n = 0; n < NUM_NEURONS; n++) img[n] = 8'h00;
    stream(-1, -1, -1);

    // weights 01..0C: XOR is 0C
    for (int n = 0; n < NUM_NEURONS; n++) begin
      wr(n, 8'(n+1));
      img[n] = 8'(n+1);
    end
    stream(-1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
